// File: rtl/mem_access.sv
// rtl/mem_access.sv - rv32 memory-access stage with single-outstanding data bus FSM
package mem_access_pkg;
   localparam int RegWidth = 32;

   typedef struct packed {
      logic       valid;
      logic       mem_rd;
      logic       mem_wr;
      logic [2:0] func3;
      logic       wb_en;
   } ctrl_t;

   typedef struct packed {
      logic [RegWidth-1:0] value;
   } src_t;

   typedef struct packed {
      logic [4:0]          addr;
      logic [RegWidth-1:0] value;
   } reg_t;

   typedef struct packed {
      ctrl_t ctrl;
      src_t  rs;
      reg_t  rd;
   } ex_mem_t;

   typedef struct packed {
      ctrl_t ctrl;
      reg_t  rd;
   } mem_wb_t;
endpackage

module mem_access
   import mem_access_pkg::*;
#(
   parameter logic [7:0] BusTimeout = 8'd255
) (
   input  logic                iClk,
   input  logic                nRst,
   input  logic                iStall,
   input  logic                iFlush,
   input  ex_mem_t             iEX,
   output mem_wb_t             oWB,
   output logic [RegWidth-1:0] oFwMe,
   output logic                oStall,
   output logic                oDReq,
   output logic                oDWe,
   output logic [31:0]         oDAddr,
   output logic [31:0]         oDWData,
   output logic [3:0]          oDBe,
   input  logic                iDAck,
   input  logic                iDErr,
   input  logic [31:0]         iDRData,
   output logic                oMisalign,
   output logic                oBusErr
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        flushed_q;
   logic        req_q, we_q, misalign_q, buserr_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   mem_wb_t     ex_q, rbuf_q, wb_q;

   logic        memop, misalign, aligned, timeout, resp, err;
   logic [1:0]  off;
   logic [31:0] wdata_d, load_d, shifted;
   logic [3:0]  be_d;
   mem_wb_t     pass_d, result_d;

   assign memop    = iEX.ctrl.valid & (iEX.ctrl.mem_rd | iEX.ctrl.mem_wr);
   assign off      = iEX.rd.value[1:0];
   assign misalign = memop & (((iEX.ctrl.func3[1:0] == 2'b01) & off[0]) |
                              ((iEX.ctrl.func3[1:0] == 2'b10) & (off != 2'b00)));
   assign aligned  = memop & ~misalign;
   assign timeout  = (state_q == BUSY) & (cnt_q == BusTimeout - 8'd1);
   assign resp     = (state_q == BUSY) & (iDAck | timeout);
   // A timeout counts as an errored ack; a real ack always wins over a coincident timeout.
   assign err      = (iDAck & iDErr) | (~iDAck & timeout);
   assign shifted  = iDRData >> {off_q, 3'b000};

   // Store lane replication and byte enables; loads read the whole word.
   always_comb begin
      wdata_d = iEX.rs.value;
      be_d    = 4'b1111;
      if (iEX.ctrl.mem_wr) begin
         case (iEX.ctrl.func3[1:0])
            2'b00:   begin wdata_d = {4{iEX.rs.value[7:0]}};  be_d = 4'b0001 << off; end
            2'b01:   begin wdata_d = {2{iEX.rs.value[15:0]}}; be_d = 4'b0011 << off; end
            default: begin wdata_d = iEX.rs.value;            be_d = 4'b1111;        end
         endcase
      end
   end

   // Load extraction with sign or zero extension from the shifted read word.
   always_comb begin
      case (f3_q)
         3'b000:  load_d = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_d = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_d = {24'b0, shifted[7:0]};
         3'b101:  load_d = {16'b0, shifted[15:0]};
         default: load_d = shifted;
      endcase
   end

   // Records for the pass-through path and for a completing bus access.
   always_comb begin
      pass_d.ctrl = iEX.ctrl;
      pass_d.rd   = iEX.rd;
      if (misalign) pass_d.ctrl.valid = 1'b0;
      result_d = ex_q;
      if (!ex_q.ctrl.mem_wr && !err) result_d.rd.value = load_d;
      if (err) result_d.ctrl.valid = 1'b0;
      if (flushed_q || iFlush) result_d = '0;
   end

   // Upstream stall request.
   always_comb begin
      oStall = 1'b0;
      case (state_q)
         IDLE:    oStall = aligned & ~iFlush;
         BUSY:    oStall = ~(resp & ~iStall);
         DONE:    oStall = iStall;
         default: oStall = 1'b0;
      endcase
   end

   // Access FSM with registered bus, result and exception outputs.
   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         flushed_q  <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         misalign_q <= 1'b0;
         buserr_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         ex_q       <= '0;
         rbuf_q     <= '0;
         wb_q       <= '0;
      end else begin
         misalign_q <= 1'b0;
         buserr_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q     <= '0;
               flushed_q <= 1'b0;
               if (iFlush) begin
                  wb_q <= '0;
               end else if (!iStall) begin
                  if (aligned) begin
                     addr_q  <= {iEX.rd.value[31:2], 2'b00};
                     wdata_q <= wdata_d;
                     be_q    <= be_d;
                     we_q    <= iEX.ctrl.mem_wr;
                     f3_q    <= iEX.ctrl.func3;
                     off_q   <= off;
                     ex_q    <= pass_d;
                     req_q   <= 1'b1;
                     wb_q    <= '0;
                     state_q <= BUSY;
                  end else begin
                     wb_q       <= pass_d;
                     misalign_q <= misalign;
                  end
               end
            end
            BUSY: begin
               if (iFlush) flushed_q <= 1'b1;
               if (resp) begin
                  req_q    <= 1'b0;
                  cnt_q    <= '0;
                  buserr_q <= err & ~(flushed_q | iFlush);
                  if (!iStall) begin
                     wb_q      <= result_d;
                     flushed_q <= 1'b0;
                     state_q   <= IDLE;
                  end else begin
                     rbuf_q  <= result_d;
                     state_q <= DONE;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: begin
               if (iFlush) flushed_q <= 1'b1;
               if (!iStall) begin
                  wb_q      <= (flushed_q | iFlush) ? '0 : rbuf_q;
                  flushed_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign oWB       = wb_q;
   assign oFwMe     = wb_q.rd.value;
   assign oDReq     = req_q;
   assign oDWe      = we_q;
   assign oDAddr    = addr_q;
   assign oDWData   = wdata_q;
   assign oDBe      = be_q;
   assign oMisalign = misalign_q;
   assign oBusErr   = buserr_q;

endmodule
